// File: rtl/serialize_bit_sequence_if.sv
// Handshake bundle between a pattern source and the bit serializer.
// The master modport loads patterns and consumes bits; the slave modport is the serializer.
interface serialize_bit_sequence_if #(
  parameter int W     = 6,
  parameter int LEN_W = $clog2(W + 1),
  parameter int RPT_W = 4
);
  logic             start;
  logic [W-1:0]     pattern;
  logic [LEN_W-1:0] len;
  logic [RPT_W-1:0] reps;
  logic             abort;
  logic             out_ready;
  logic             new_bit;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, len, reps, abort, out_ready,
    input  new_bit, out_valid, busy, done
  );

  modport slave (
    input  start, pattern, len, reps, abort, out_ready,
    output new_bit, out_valid, busy, done
  );
endinterface

// File: rtl/serialize_bit_sequence.sv
// Serializes a captured pattern MSB first, repeated reps+1 times, behind a
// valid/ready handshake. All outputs are registered.
module serialize_bit_sequence #(
  parameter int W     = 6,
  parameter int LEN_W = $clog2(W + 1),
  parameter int RPT_W = 4
) (
  input logic                    clk,
  input logic                    rst,
  serialize_bit_sequence_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [W-1:0]     pat_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] idx_r;
  logic [RPT_W-1:0] cnt_r;
  logic             new_bit_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             done_r;
  logic             legal_len_s;

  // Bit select that never indexes past the pattern, whatever the index width.
  function automatic logic bit_at(input logic [W-1:0] p, input logic [LEN_W-1:0] i);
    logic b;
    b = 1'b0;
    for (int k = 0; k < W; k++) begin
      b = (i == LEN_W'(k)) ? p[k] : b;
    end
    return b;
  endfunction

  assign legal_len_s = (bus.len != {LEN_W{1'b0}}) && (bus.len <= LEN_W'(W));

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      pat_r       <= {W{1'b0}};
      len_r       <= {LEN_W{1'b0}};
      idx_r       <= {LEN_W{1'b0}};
      cnt_r       <= {RPT_W{1'b0}};
      new_bit_r   <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start && !bus.abort && legal_len_s) begin
            state_r     <= SEND;
            pat_r       <= bus.pattern;
            len_r       <= bus.len;
            idx_r       <= bus.len - LEN_W'(1);
            cnt_r       <= bus.reps;
            new_bit_r   <= bit_at(bus.pattern, bus.len - LEN_W'(1));
            out_valid_r <= 1'b1;
            busy_r      <= 1'b1;
          end else begin
            new_bit_r   <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        SEND: begin
          if (bus.abort) begin
            state_r     <= IDLE;
            new_bit_r   <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
          end else if (bus.out_ready) begin
            if (idx_r == {LEN_W{1'b0}}) begin
              if (cnt_r != {RPT_W{1'b0}}) begin
                // Next repetition starts back-to-back with no idle gap.
                cnt_r     <= cnt_r - RPT_W'(1);
                idx_r     <= len_r - LEN_W'(1);
                new_bit_r <= bit_at(pat_r, len_r - LEN_W'(1));
              end else begin
                state_r     <= DONE;
                new_bit_r   <= 1'b0;
                out_valid_r <= 1'b0;
                done_r      <= 1'b1;
              end
            end else begin
              idx_r     <= idx_r - LEN_W'(1);
              new_bit_r <= bit_at(pat_r, idx_r - LEN_W'(1));
            end
          end else begin
            state_r <= SEND;
          end
        end
        DONE: begin
          state_r     <= IDLE;
          new_bit_r   <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          new_bit_r   <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.new_bit   = new_bit_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_serialize_bit_sequence.sv
// Randomized and directed bench for serialize_bit_sequence against a queue-based
// model of the expected bit stream.
module tb_serialize_bit_sequence;

  localparam int W     = 6;
  localparam int LEN_W = $clog2(W + 1);
  localparam int RPT_W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // Reference: bits still to be sent, plus a flag for the one-cycle done phase.
  bit   exp_q[$];
  bit   in_done;

  serialize_bit_sequence_if #(.W(W), .LEN_W(LEN_W), .RPT_W(RPT_W)) bus ();

  serialize_bit_sequence #(.W(W), .LEN_W(LEN_W), .RPT_W(RPT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic ev;
    ev = (exp_q.size() > 0);
    check_eq({tag, ".out_valid"}, bus.out_valid, ev);
    check_eq({tag, ".new_bit"}, bus.new_bit, ev ? exp_q[0] : 1'b0);
    check_eq({tag, ".busy"}, bus.busy, ev || in_done);
    check_eq({tag, ".done"}, bus.done, in_done);
  endtask

  // Apply the rules for one clock edge given the inputs present at that edge.
  task automatic model_edge(input logic s, input logic [W-1:0] p, input logic [LEN_W-1:0] l,
                            input logic [RPT_W-1:0] r, input logic a, input logic o);
    if (in_done) begin
      in_done = 1'b0;
    end else if (exp_q.size() > 0) begin
      if (a) begin
        exp_q.delete();
      end else if (o) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) in_done = 1'b1;
      end
    end else if (s && !a && l >= 1 && l <= W) begin
      for (int rep = 0; rep <= int'(r); rep++)
        for (int i = int'(l) - 1; i >= 0; i--)
          exp_q.push_back(p[i]);
    end
  endtask

  task automatic step(input string tag, input logic s, input logic [W-1:0] p,
                      input logic [LEN_W-1:0] l, input logic [RPT_W-1:0] r,
                      input logic a, input logic o);
    @(negedge clk);
    bus.start     = s;
    bus.pattern   = p;
    bus.len       = l;
    bus.reps      = r;
    bus.abort     = a;
    bus.out_ready = o;
    @(posedge clk);
    model_edge(s, p, l, r, a, o);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_steps(input string tag, input int n, input logic o);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 6'b000000, 3'd0, 4'd0, 1'b0, o);
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    checks = 0;
    failures = 0;
    in_done = 1'b0;
    bus.start = 1'b0; bus.pattern = 6'b000000; bus.len = 3'd0;
    bus.reps = 4'd0; bus.abort = 1'b0; bus.out_ready = 1'b0;
    #3;
    check_outputs("reset_hold");
    @(negedge clk);
    rst = 1'b1;
    idle_steps("post_reset", 2, 1'b1);

    // Basic send: 110011
    step("basic_load", 1'b1, 6'b110011, 3'd6, 4'd0, 1'b0, 1'b1);
    idle_steps("basic", 8, 1'b1);

    // Repeat: 1010 x3
    step("rpt_load", 1'b1, 6'b001010, 3'd4, 4'd2, 1'b0, 1'b1);
    idle_steps("rpt", 14, 1'b1);

    // Backpressure on t+2, t+3
    step("bp_load", 1'b1, 6'b110011, 3'd6, 4'd0, 1'b0, 1'b1);
    idle_steps("bp_a", 1, 1'b1);
    idle_steps("bp_stall", 2, 1'b0);
    idle_steps("bp_b", 7, 1'b1);

    // Illegal lengths ignored
    step("len0", 1'b1, 6'b111111, 3'd0, 4'd1, 1'b0, 1'b1);
    idle_steps("len0_idle", 2, 1'b1);
    step("len7", 1'b1, 6'b111111, 3'd7, 4'd1, 1'b0, 1'b1);
    idle_steps("len7_idle", 2, 1'b1);

    // Second start mid-transfer ignored
    step("busy_load", 1'b1, 6'b110011, 3'd6, 4'd0, 1'b0, 1'b1);
    idle_steps("busy_a", 2, 1'b1);
    step("busy_restart", 1'b1, 6'b010101, 3'd5, 4'd3, 1'b0, 1'b1);
    idle_steps("busy_b", 6, 1'b1);

    // Abort at t+3, then restart
    step("abort_load", 1'b1, 6'b110011, 3'd6, 4'd0, 1'b0, 1'b1);
    idle_steps("abort_a", 2, 1'b1);
    step("abort", 1'b0, 6'b000000, 3'd0, 4'd0, 1'b1, 1'b1);
    step("abort_gap", 1'b0, 6'b000000, 3'd0, 4'd0, 1'b0, 1'b1);
    step("abort_reload", 1'b1, 6'b101100, 3'd6, 4'd0, 1'b0, 1'b1);
    idle_steps("abort_b", 8, 1'b1);
    step("abort_start_idle", 1'b1, 6'b111111, 3'd3, 4'd0, 1'b1, 1'b1);
    idle_steps("abort_idle", 1, 1'b1);

    // Async reset mid-SEND
    step("ar_load", 1'b1, 6'b111111, 3'd6, 4'd2, 1'b0, 1'b1);
    idle_steps("ar_a", 2, 1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    exp_q.delete();
    in_done = 1'b0;
    #1;
    check_outputs("async_reset");
    bus.start = 1'b0; bus.abort = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    idle_steps("ar_idle", 3, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic s, a, o;
      logic [W-1:0] p;
      logic [LEN_W-1:0] l;
      logic [RPT_W-1:0] r;
      s = ($urandom_range(0, 2) == 0);
      a = ($urandom_range(0, 24) == 0);
      o = ($urandom_range(0, 3) != 0);
      p = W'($urandom);
      l = LEN_W'($urandom_range(0, 7));
      r = RPT_W'($urandom_range(0, 3));
      step("rand", s, p, l, r, a, o);
    end
    idle_steps("drain", 40, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
